// File: rtl/gate_tt_checker.sv
// Truth-table sweep checker: steps vec_out through every input combination of a
// gate under test, samples dut_out and compares it with EXPECT. Optional macro GATE_CHK_LOOP_EN.
module gate_tt_checker #(
    parameter int                     N_IN        = 2,
    parameter int                     HOLD_CYCLES = 4,
    parameter logic [(2**N_IN)-1:0]   EXPECT      = 4'b1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
`ifdef GATE_CHK_LOOP_EN
    input  logic            stop,
`endif
    input  logic            dut_out,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [7:0]      err_cnt,
    output logic [N_IN-1:0] fail_idx
);

    localparam int            HW      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] LAST  = '1;

    // DONE is folded into the return to IDLE: done stays registered while idle
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE} state_t;

    state_t          r_state, w_state;
    logic [N_IN-1:0] r_idx, w_idx;
    logic [HW-1:0]   r_hold, w_hold;
    logic            r_busy, w_busy;
    logic            r_done, w_done;
    logic            r_pass, w_pass;
    logic [7:0]      r_err, w_err;
    logic [N_IN-1:0] r_fail, w_fail;

    logic            w_mism;
    logic [7:0]      w_err_inc;
    logic            w_stop;

    assign w_mism    = (dut_out != EXPECT[r_idx]);
    assign w_err_inc = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
`ifdef GATE_CHK_LOOP_EN
    assign w_stop    = stop;
`else
    assign w_stop    = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_hold  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fail  <= '0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_hold  <= w_hold;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pass  <= w_pass;
            r_err   <= w_err;
            r_fail  <= w_fail;
        end
    end

    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_hold  = r_hold;
        w_busy  = r_busy;
        w_done  = r_done;
        w_pass  = r_pass;
        w_err   = r_err;
        w_fail  = r_fail;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_busy  = 1'b1;
                    w_done  = 1'b0;
                    w_pass  = 1'b0;
                    w_err   = '0;
                    w_fail  = '0;
                    w_idx   = '0;
                    w_hold  = HOLD_LD;
                    w_state = S_DRIVE;
                end
            end
            S_DRIVE: begin
                // also terminates the one-cycle done pulse of a looping sweep
                w_done = 1'b0;
                if (r_hold == '0) w_state = S_SAMPLE;
                else              w_hold  = r_hold - 1'b1;
            end
            S_SAMPLE: begin
                if (w_mism) begin
                    w_err = w_err_inc;
                    if (r_err == 8'd0) w_fail = r_idx;
                end
                w_idx   = r_idx + 1'b1;
                w_hold  = HOLD_LD;
                w_state = S_DRIVE;
                if (r_idx == LAST) begin
                    w_done = 1'b1;
                    w_pass = (w_err == 8'd0);
                    if (w_stop) begin
                        // hold the last vector on the gate inputs while idle
                        w_idx   = r_idx;
                        w_busy  = 1'b0;
                        w_state = S_IDLE;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign vec_out  = r_idx;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign err_cnt  = r_err;
    assign fail_idx = r_fail;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: gate models as truth tables, expected results from
// a table comparison and from the sweep timing rule (HOLD_CYCLES+1 cycles per vector).
module tb_gate_tt_checker;

    localparam int         N_IN = 2;
    localparam int         HOLD = 4;
    localparam int         NV   = 4;
    localparam int         H1   = HOLD + 1;
    localparam logic [3:0] EXP  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       dut_out;
    logic [1:0] vec_out;
    logic       busy, done, pass;
    logic [7:0] err_cnt;
    logic [1:0] fail_idx;
    logic [3:0] tt;

    int n_chk  = 0;
    int n_fail = 0;

    gate_tt_checker #(.N_IN(N_IN), .HOLD_CYCLES(HOLD), .EXPECT(EXP)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef GATE_CHK_LOOP_EN
        .stop     (stop),
`endif
        .dut_out  (dut_out),
        .vec_out  (vec_out),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .fail_idx (fail_idx)
    );

    always #5 clk = ~clk;
    assign dut_out = tt[vec_out];

    // Precondition: at a negedge. If started=0 the task issues the start pulse;
    // otherwise the start was accepted at the previous posedge. extra adds start
    // pulses at edges 7 and 19 that must be ignored.
    task automatic run_sweep(input string nm, input logic [3:0] t, input bit started, input bit extra);
        int         e_err  = 0;
        logic [1:0] e_fidx = 2'd0;
        logic [1:0] ev;
        logic       eb, ed;
        for (int k = 0; k < NV; k++)
            if (t[k] != EXP[k]) begin
                if (e_err == 0) e_fidx = 2'(k);
                e_err++;
            end
        tt = t;
        if (!started) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int e = 0; e <= NV * H1; e++) begin
            ev = (e < NV * H1) ? 2'(e / H1) : 2'(NV - 1);
            eb = (e < NV * H1);
            ed = (e == NV * H1);
            n_chk++;
            if ({vec_out, busy, done} !== {ev, eb, ed}) begin
                n_fail++;
                $display("FAIL %s edge %0d: vec/busy/done got %0d/%0b/%0b want %0d/%0b/%0b",
                         nm, e, vec_out, busy, done, ev, eb, ed);
            end
            start = extra && (e == 6 || e == 18);
            if (e < NV * H1) @(negedge clk);
        end
        start = 1'b0;
        n_chk++;
        if ({err_cnt, fail_idx, pass} !== {8'(e_err), e_fidx, (e_err == 0)}) begin
            n_fail++;
            $display("FAIL %s result: err/fidx/pass got %0d/%0d/%0b want %0d/%0d/%0b",
                     nm, err_cnt, fail_idx, pass, e_err, e_fidx, (e_err == 0));
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; stop = 1'b1; tt = EXP;
        #3;
        n_chk++;
        if ({vec_out, busy, done, pass, err_cnt, fail_idx} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset: outputs got %h want 0", {vec_out, busy, done, pass, err_cnt, fail_idx});
        end
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
    endtask

    task automatic test_models;
        run_sweep("and",    4'b1000, 1'b0, 1'b0);
        @(negedge clk);
        run_sweep("or",     4'b1110, 1'b0, 1'b0);
        @(negedge clk);
        run_sweep("stuck1", 4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        run_sweep("stuck0", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            run_sweep("rand", 4'($urandom_range(0, 15)), 1'b0, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        tt = 4'b1000;
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (12) @(negedge clk);
        n_chk++;
        if (vec_out !== 2'd2) begin
            n_fail++;
            $display("FAIL midreset pre: vec got %0d want 2", vec_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({vec_out, busy, done, pass, err_cnt, fail_idx} !== 14'd0) begin
            n_fail++;
            $display("FAIL midreset: outputs got %h want 0", {vec_out, busy, done, pass, err_cnt, fail_idx});
        end
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        run_sweep("after_reset", 4'b1000, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        run_sweep("busy_start", 4'b1110, 1'b0, 1'b1);
        // still on the done cycle: this start must be accepted immediately
        start = 1'b1; @(negedge clk); start = 1'b0;
        run_sweep("restart", 4'b0110, 1'b1, 1'b0);
        @(negedge clk);
    endtask

`ifdef GATE_CHK_LOOP_EN
    task automatic test_loop;
        logic eb, ed;
        tt = 4'b1110; stop = 1'b0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int e = 0; e <= 3 * NV * H1; e++) begin
            ed = (e == 20 || e == 40 || e == 60);
            eb = (e < 60);
            n_chk++;
            if ({busy, done} !== {eb, ed}) begin
                n_fail++;
                $display("FAIL loop edge %0d: busy/done got %0b/%0b want %0b/%0b", e, busy, done, eb, ed);
            end
            if (e == 45) stop = 1'b1;
            if (e < 60) @(negedge clk);
        end
        n_chk++;
        if ({err_cnt, fail_idx, pass} !== {8'd6, 2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL loop result: err/fidx/pass got %0d/%0d/%0b want 6/1/0", err_cnt, fail_idx, pass);
        end
        @(negedge clk);
        n_chk++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL loop hold: done got %0b want 1", done);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_models;
        test_random;
        test_reset_mid;
        test_back_to_back;
`ifdef GATE_CHK_LOOP_EN
        test_loop;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
